// File: rtl/out_port_buffered.sv
// Buffered output port: W-bus writes queue in a FIFO and drain either as a
// parallel word under valid/ack or as an LSB-first serial stream.
module out_port_buffered #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic [WIDTH-1:0]         iData,
    input  logic                     iLoad,
    input  logic                     iMode,
    input  logic                     iAck,
    input  logic                     iClrOvf,
    output logic [WIDTH-1:0]         oData,
    output logic                     oValid,
    output logic                     oSerial,
    output logic                     oSerValid,
    output logic                     oSerLast,
    output logic                     oFull,
    output logic                     oEmpty,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oOverflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAR  = 2'd1,
        SER  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_next;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_next;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_next;
    logic [WIDTH-1:0]   data_next;
    logic               valid_next;
    logic               ser_valid_next;
    logic               ser_last_next;
    logic               push;
    logic               pop;

    // Full is the registered pre-edge status, so a load while full is dropped
    // even when a pop frees a slot at the same edge.
    assign push = iLoad && !oFull;

    // Shift register empties to zero by the end of a word, so the serial line idles low.
    assign oSerial = shreg[0];

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        bit_cnt_next   = bit_cnt;
        data_next      = oData;
        valid_next     = oValid;
        ser_valid_next = oSerValid;
        ser_last_next  = oSerLast;
        pop            = 1'b0;
        case (state)
            IDLE: begin
                if (!oEmpty) begin
                    pop = 1'b1;
                    if (!iMode) begin
                        data_next  = mem[rd_ptr];
                        valid_next = 1'b1;
                        state_next = PAR;
                    end else begin
                        shreg_next     = mem[rd_ptr];
                        bit_cnt_next   = '0;
                        ser_valid_next = 1'b1;
                        ser_last_next  = 1'b0;
                        state_next     = SER;
                    end
                end
            end
            PAR: begin
                if (iAck) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            SER: begin
                shreg_next   = shreg >> 1;
                bit_cnt_next = bit_cnt + 1'b1;
                if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                    ser_valid_next = 1'b0;
                    ser_last_next  = 1'b0;
                    state_next     = IDLE;
                end else begin
                    ser_last_next = (bit_cnt == BIT_W'(WIDTH - 2));
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = oCount + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr] <= iData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            oCount    <= '0;
            oFull     <= 1'b0;
            oEmpty    <= 1'b1;
            oOverflow <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            oData     <= '0;
            oValid    <= 1'b0;
            oSerValid <= 1'b0;
            oSerLast  <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            bit_cnt   <= bit_cnt_next;
            oData     <= data_next;
            oValid    <= valid_next;
            oSerValid <= ser_valid_next;
            oSerLast  <= ser_last_next;
            oCount    <= count_next;
            oFull     <= (count_next == CNT_W'(DEPTH));
            oEmpty    <= (count_next == '0);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A new overflow takes priority over a simultaneous clear.
            if (iLoad && oFull) begin
                oOverflow <= 1'b1;
            end else if (iClrOvf) begin
                oOverflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_out_port_buffered.sv
// Scoreboard bench for out_port_buffered: stimulus queues expected words/bits,
// a negedge monitor compares them whenever the DUT presents output.
module tb_out_port_buffered;

    logic       iClk;
    logic       iReset;
    logic [7:0] iData;
    logic       iLoad;
    logic       iMode;
    logic       iAck;
    logic       iClrOvf;
    logic [7:0] oData;
    logic       oValid;
    logic       oSerial;
    logic       oSerValid;
    logic       oSerLast;
    logic       oFull;
    logic       oEmpty;
    logic [2:0] oCount;
    logic       oOverflow;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] par_q[$];
    logic [1:0] ser_q[$];
    logic       started = 1'b0;
    logic       prev_valid = 1'b0;

    out_port_buffered #(.WIDTH(8), .DEPTH(4)) dut (
        .iClk(iClk), .iReset(iReset), .iData(iData), .iLoad(iLoad),
        .iMode(iMode), .iAck(iAck), .iClrOvf(iClrOvf), .oData(oData),
        .oValid(oValid), .oSerial(oSerial), .oSerValid(oSerValid),
        .oSerLast(oSerLast), .oFull(oFull), .oEmpty(oEmpty),
        .oCount(oCount), .oOverflow(oOverflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic push_ser(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ser_q.push_back({(i == 7), w[i]});
        end
    endtask

    // Monitor: a new parallel word is an oValid rising edge; every oSerValid cycle is one bit.
    always @(negedge iClk) begin
        if (started) begin
            if (oValid && !prev_valid) begin
                if (par_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL par_unexpected: got %0h expected no word", oData);
                end else begin
                    check("par_word", 32'(oData), 32'(par_q.pop_front()));
                end
            end
            prev_valid = oValid;
            if (oSerValid) begin
                if (ser_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL ser_unexpected: got bit %0d expected no bit", oSerial);
                end else begin
                    logic [1:0] e;
                    e = ser_q.pop_front();
                    check("ser_bit", 32'(oSerial), 32'(e[0]));
                    check("ser_last", 32'(oSerLast), 32'(e[1]));
                end
            end else if (oSerLast) begin
                vectors++;
                errors++;
                $display("FAIL ser_last_idle: got 1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iReset = 1'b1; iData = '0; iLoad = 1'b0; iMode = 1'b0; iAck = 1'b0; iClrOvf = 1'b0;
        tick(); tick();
        iReset = 1'b0;
        check("rst_data", 32'(oData), 32'h0);
        check("rst_valid", 32'(oValid), 32'h0);
        check("rst_serial", 32'(oSerial), 32'h0);
        check("rst_servalid", 32'(oSerValid), 32'h0);
        check("rst_serlast", 32'(oSerLast), 32'h0);
        check("rst_count", 32'(oCount), 32'h0);
        check("rst_empty", 32'(oEmpty), 32'h1);
        check("rst_full", 32'(oFull), 32'h0);
        check("rst_ovf", 32'(oOverflow), 32'h0);
        started = 1'b1;

        // Single parallel word
        iLoad = 1'b1; iData = 8'hA5; par_q.push_back(8'hA5);
        tick();
        iLoad = 1'b0;
        check("p1_count1", 32'(oCount), 32'h1);
        check("p1_empty0", 32'(oEmpty), 32'h0);
        tick();
        check("p1_count0", 32'(oCount), 32'h0);
        check("p1_valid", 32'(oValid), 32'h1);
        check("p1_data", 32'(oData), 32'hA5);
        iAck = 1'b1; tick(); iAck = 1'b0;
        check("p1_ack_valid", 32'(oValid), 32'h0);
        check("p1_data_hold", 32'(oData), 32'hA5);
        tick();

        // Fill and overflow: 0x06 arrives while full and is dropped
        for (int i = 1; i <= 6; i++) begin
            iLoad = 1'b1; iData = 8'(i);
            if (i <= 5) par_q.push_back(8'(i));
            tick();
        end
        iLoad = 1'b0;
        check("fill_ovf", 32'(oOverflow), 32'h1);
        check("fill_full", 32'(oFull), 32'h1);
        check("fill_count", 32'(oCount), 32'h4);
        check("fill_head", 32'(oData), 32'h01);
        for (int i = 0; i < 5; i++) begin
            iAck = 1'b1; tick(); iAck = 1'b0; tick();
        end
        check("drain_count", 32'(oCount), 32'h0);
        check("drain_empty", 32'(oEmpty), 32'h1);
        check("drain_ovf_sticky", 32'(oOverflow), 32'h1);
        iClrOvf = 1'b1; tick(); iClrOvf = 1'b0;
        check("clr_ovf", 32'(oOverflow), 32'h0);

        // Serial word 0xC3
        iMode = 1'b1; iLoad = 1'b1; iData = 8'hC3; push_ser(8'hC3, 8);
        tick();
        iLoad = 1'b0;
        tick();
        check("ser_start", 32'(oSerValid), 32'h1);
        repeat (8) tick();
        check("ser_end_valid", 32'(oSerValid), 32'h0);
        check("ser_end_line", 32'(oSerial), 32'h0);
        tick();

        // Mixed modes, with a load coinciding with an IDLE pop at count 1
        iMode = 1'b0; iLoad = 1'b1; iData = 8'h12; par_q.push_back(8'h12);
        tick();
        iData = 8'h34; push_ser(8'h34, 8);
        tick();
        iLoad = 1'b0; iMode = 1'b1;
        check("sim_count", 32'(oCount), 32'h1);
        check("mix_valid", 32'(oValid), 32'h1);
        iAck = 1'b1; tick(); iAck = 1'b0;
        check("mix_ack", 32'(oValid), 32'h0);
        tick();
        check("mix_ser", 32'(oSerValid), 32'h1);
        iAck = 1'b1;
        repeat (8) tick();
        iAck = 1'b0;
        check("mix_ack_ignored", 32'(oValid), 32'h0);
        check("mix_ser_done", 32'(oSerValid), 32'h0);
        check("mix_count", 32'(oCount), 32'h0);

        // Load while full at the same edge as a pop
        iMode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iLoad = 1'b1; iData = 8'(8'h21 + i); par_q.push_back(8'(8'h21 + i));
            tick();
        end
        iLoad = 1'b0;
        check("full2_full", 32'(oFull), 32'h1);
        check("full2_ovf0", 32'(oOverflow), 32'h0);
        iAck = 1'b1; tick(); iAck = 1'b0;
        iLoad = 1'b1; iData = 8'h26;
        tick();
        iLoad = 1'b0;
        check("popfull_ovf", 32'(oOverflow), 32'h1);
        check("popfull_count", 32'(oCount), 32'h3);
        for (int i = 0; i < 4; i++) begin
            iAck = 1'b1; tick(); iAck = 1'b0; tick();
        end
        check("popfull_drain", 32'(oCount), 32'h0);
        iClrOvf = 1'b1; tick(); iClrOvf = 1'b0;

        // Reset after bit 3 of 0xFF
        iMode = 1'b1; iLoad = 1'b1; iData = 8'hFF; push_ser(8'hFF, 4);
        tick();
        iLoad = 1'b0;
        tick();
        repeat (3) tick();
        iReset = 1'b1;
        tick();
        check("mrst_servalid", 32'(oSerValid), 32'h0);
        check("mrst_serial", 32'(oSerial), 32'h0);
        check("mrst_count", 32'(oCount), 32'h0);
        check("mrst_empty", 32'(oEmpty), 32'h1);
        check("mrst_serlast", 32'(oSerLast), 32'h0);
        iReset = 1'b0; iMode = 1'b0;
        repeat (3) tick();
        check("mrst_idle", 32'(oSerValid), 32'h0);

        check("par_q_drained", 32'(par_q.size()), 32'h0);
        check("ser_q_drained", 32'(ser_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
